// File: rtl/data_arb_pkg.sv
// Shared types for the two-requester data bus arbiter: requester IDs,
// arbitration states and the default outstanding-transaction depth.
package data_arb_pkg;
  typedef enum logic {REQ_CORE = 1'b0, REQ_SB = 1'b1} req_id_t;
  typedef enum logic {ARB = 1'b0, HOLD = 1'b1} arb_state_t;
  localparam int MAX_OUTSTANDING_DEFAULT = 2;
endpackage

// File: rtl/data_bus_arbiter_if.sv
// One request/response data bus port; master drives the request,
// slave answers with grant and in-order read responses.
interface data_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    req;
  logic                    we;
  logic [DATA_WIDTH/8-1:0] be;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/data_arb_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// Pointers wrap modulo DEPTH so non-power-of-two depths work.
module data_arb_id_fifo
  import data_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEFAULT
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  logic    pop,
  input  req_id_t id_in,
  output req_id_t id_out,
  output logic    full,
  output logic    empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  req_id_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign id_out  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= id_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the core (m0) and the
// debug system-bus requester (m1); responses are routed back in grant order.
module data_bus_arbiter
  import data_arb_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  output logic                    s_req_o,
  output logic                    s_we_o,
  output logic [DATA_WIDTH/8-1:0] s_be_o,
  output logic [ADDR_WIDTH-1:0]   s_addr_o,
  output logic [DATA_WIDTH-1:0]   s_wdata_o,
  input  logic                    s_gnt_i,
  input  logic                    s_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   s_rdata_i,
  output logic                    err_o
);
  arb_state_t state;
  req_id_t    sel, held, last, head;
  logic       sel_req, hs, full, empty, pop;

  // In HOLD the selection is frozen so the slave sees a stable request.
  always_comb begin
    sel = REQ_CORE;
    if (state == HOLD)             sel = held;
    else if (m0_req_i && m1_req_i) sel = (last == REQ_CORE) ? REQ_SB : REQ_CORE;
    else if (m1_req_i)             sel = REQ_SB;
  end

  always_comb begin
    sel_req   = m0_req_i;
    s_we_o    = m0_we_i;
    s_be_o    = m0_be_i;
    s_addr_o  = m0_addr_i;
    s_wdata_o = m0_wdata_i;
    if (sel == REQ_SB) begin
      sel_req   = m1_req_i;
      s_we_o    = m1_we_i;
      s_be_o    = m1_be_i;
      s_addr_o  = m1_addr_i;
      s_wdata_o = m1_wdata_i;
    end
  end

  // A full ID FIFO blocks new requests even if a response frees a slot now.
  assign s_req_o  = !rst_i && !full && sel_req;
  assign hs       = s_req_o && s_gnt_i;
  assign m0_gnt_o = hs && (sel == REQ_CORE);
  assign m1_gnt_o = hs && (sel == REQ_SB);

  assign pop         = !rst_i && s_rvalid_i && !empty;
  assign m0_rvalid_o = pop && (head == REQ_CORE);
  assign m1_rvalid_o = pop && (head == REQ_SB);
  assign m0_rdata_o  = s_rdata_i;
  assign m1_rdata_o  = s_rdata_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ARB;
      held  <= REQ_CORE;
      last  <= REQ_SB;
      err_o <= 1'b0;
    end else begin
      if (s_rvalid_i && empty) err_o <= 1'b1;
      if (hs) last <= sel;
      case (state)
        ARB: if (s_req_o && !s_gnt_i) begin
          state <= HOLD;
          held  <= sel;
        end
        HOLD: if (!sel_req) begin
          err_o <= 1'b1;
          state <= ARB;
        end else if (hs) begin
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

  data_arb_id_fifo #(.DEPTH(MAX_OUTSTANDING)) u_id_fifo (
    .clk    (clk_i),
    .rst    (rst_i),
    .push   (hs),
    .pop    (pop),
    .id_in  (sel),
    .id_out (head),
    .full   (full),
    .empty  (empty)
  );
endmodule

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 2, maximum granted-but-unanswered transactions; legal range 1..4.
REQ-004 SHALL have the following ports.
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset; synchronous, active-high.
- m0_req_i, m0_we_i  in  1  core data request and write enable.
- m0_be_i  in  DATA_WIDTH/8  core byte enables.
- m0_addr_i, m0_wdata_i  in  ADDR_WIDTH, DATA_WIDTH  core address and write data.
- m0_gnt_o, m0_rvalid_o  out  1  core grant and response valid.
- m0_rdata_o  out  DATA_WIDTH  core read data.
- m1_*  same set as m0_*  debug-module system-bus requester.
- s_req_o, s_we_o  out  1  memory request and write enable.
- s_be_o, s_addr_o, s_wdata_o  out  as m0  memory byte enables, address, write data.
- s_gnt_i, s_rvalid_i  in  1  memory grant and response valid.
- s_rdata_i  in  DATA_WIDTH  memory read data.
- err_o  out  1  sticky protocol-error flag.

Function
REQ-005 SHALL forward exactly one requester's req/we/be/addr/wdata to s_* combinationally; the selection is named sel.
REQ-006 SHALL assert mX_gnt_o = s_gnt_i && s_req_o && (sel==X); the unselected requester's gnt SHALL be 0.
REQ-007 SHALL force s_req_o=0 while outstanding count == MAX_OUTSTANDING, even if s_rvalid_i is high in that cycle.
REQ-008 SHALL implement arbitration FSM states ARB and HOLD.
- ARB: sel is the single requester if only one requests; if both request, sel is the one not granted last (round-robin).
- ARB -> HOLD when s_req_o && !s_gnt_i; sel is registered.
- HOLD: sel stays frozen until s_req_o && s_gnt_i, then -> ARB.
- If the held requester drops req in HOLD (protocol violation), SHALL set err_o and return to ARB.
REQ-009 SHALL update the last-granted pointer on every handshake (s_req_o && s_gnt_i).
REQ-010 SHALL push sel into an in-order ID FIFO on every handshake.
REQ-011 SHALL pop the FIFO on s_rvalid_i and assert rvalid only to the popped owner, in the same cycle with zero latency.
REQ-012 SHALL drive s_rdata_i to both mX_rdata_o unconditionally.
REQ-013 SHALL handle push and pop in the same cycle with count unchanged; FIFO pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-014 SHALL set err_o on s_rvalid_i with an empty FIFO, route rvalid to neither requester, and leave the count at 0.
REQ-015 SHALL clear err_o only by reset.

Reset
REQ-016 On rst_i sampled high: FSM=ARB, last-granted=m1 (so m0 wins the first tie), FIFO empty, count=0, err_o=0.
REQ-017 During reset, s_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o and m1_rvalid_o SHALL be 0.
REQ-018 Reset mid-transaction SHALL discard all outstanding IDs; a subsequent unmatched s_rvalid_i SHALL set err_o per REQ-014.

Structure
REQ-019 Package data_arb_pkg SHALL hold the requester-ID type (REQ_CORE=0, REQ_SB=1), the FSM state enum, and the MAX_OUTSTANDING default.
REQ-020 The ID FIFO SHALL be sub-module data_arb_id_fifo with push, pop, id in/out, full, empty and a sync active-high reset.
REQ-021 No other sub-modules; all s_* mux paths SHALL be combinational.

Verification
REQ-022 m0 read of 0x100 only, s_gnt_i=1, rvalid one cycle later with 0xDEADBEEF -> m0_gnt_o for 1 cycle, then m0_rvalid_o=1 with m0_rdata_o=0xDEADBEEF; m1_rvalid_o=0.
REQ-023 Both requesters hold req continuously for 4 handshakes with s_gnt_i=1 -> grant order m0,m1,m0,m1, and responses are routed in the same order.
REQ-024 s_gnt_i=0 for 3 cycles while m0 requests, and m1 raises req in cycle 2 -> s_addr_o stays m0's address; m0 is granted first, then m1.
REQ-025 MAX_OUTSTANDING=2: two grants with no rvalid -> s_req_o=0 on the third request; an rvalid in that cycle still does not grant; the next cycle grants.
REQ-026 s_rvalid_i with no outstanding transactions -> err_o=1 and stays 1; no rvalid to either requester; rst_i clears err_o.
REQ-027 rst_i asserted with 2 outstanding transactions -> count=0 after reset, the first post-reset grant goes to m0 on a tie, and a stale rvalid sets err_o.
